// File: rtl/run_len_fsm.sv
// Run-length detector: counts sampled-high cycles of x, flags partial
// progress (z1) and threshold reached (z2), with optional timed rearm.
module run_len_fsm #(
    parameter int THRESH         = 3,
    parameter int CNT_W          = 2,
    parameter bit RESTART_ON_LOW = 1'b0,
    parameter bit AUTO_REARM     = 1'b0,
    parameter int HOLD_CYC       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic             x,
    output logic             z1,
    output logic             z2,
    output logic             done_pulse,
    output logic [CNT_W-1:0] count
);

    localparam int TW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [CNT_W-1:0] THR  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [TW-1:0]    TLOD = TW'(HOLD_CYC - 1);
    localparam bit               THR1 = (THRESH == 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             pulse_q, pulse_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            timer_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        timer_d = timer_q;
        pulse_d = 1'b0;
        if (clr) begin
            state_d = IDLE;
            count_d = '0;
            timer_d = '0;
        end else if (en) begin
            case (state_q)
                IDLE: begin
                    if (x) begin
                        count_d = ONE;
                        if (THR1) begin
                            state_d = DONE;
                            timer_d = TLOD;
                            pulse_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        count_d = '0;
                    end
                end
                RUN: begin
                    if (x) begin
                        count_d = count_q + ONE;
                        if (count_q + ONE == THR) begin
                            state_d = DONE;
                            timer_d = TLOD;
                            pulse_d = 1'b1;
                        end
                    end else if (RESTART_ON_LOW) begin
                        state_d = IDLE;
                        count_d = '0;
                    end
                end
                DONE: begin
                    // sticky unless timed rearm is enabled
                    if (AUTO_REARM) begin
                        if (timer_q == '0) begin
                            state_d = IDLE;
                            count_d = '0;
                        end else begin
                            timer_d = timer_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                    timer_d = '0;
                end
            endcase
        end
    end

    assign z1         = (state_q == RUN);
    assign z2         = (state_q == DONE);
    assign done_pulse = pulse_q;
    assign count      = count_q;

endmodule

// File: tb/tb_run_len_fsm.sv
// Bench for run_len_fsm: four parameterisations driven in lockstep,
// checked against a count/done model plus hand-computed vectors.
module tb_run_len_fsm;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic x = 1'b0;

    always #5 clk = ~clk;

    logic       z1_d, z2_d, p_d;
    logic [1:0] c_d;
    logic       z1_r, z2_r, p_r;
    logic [1:0] c_r;
    logic       z1_a, z2_a, p_a;
    logic [1:0] c_a;
    logic       z1_o, z2_o, p_o;
    logic [0:0] c_o;

    run_len_fsm u_def (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .x(x),
        .z1(z1_d), .z2(z2_d), .done_pulse(p_d), .count(c_d)
    );

    run_len_fsm #(.RESTART_ON_LOW(1'b1)) u_rol (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .x(x),
        .z1(z1_r), .z2(z2_r), .done_pulse(p_r), .count(c_r)
    );

    run_len_fsm #(.AUTO_REARM(1'b1), .HOLD_CYC(4)) u_ar (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .x(x),
        .z1(z1_a), .z2(z2_a), .done_pulse(p_a), .count(c_a)
    );

    run_len_fsm #(
        .THRESH(1), .CNT_W(1), .AUTO_REARM(1'b1), .HOLD_CYC(1)
    ) u_t1 (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .x(x),
        .z1(z1_o), .z2(z2_o), .done_pulse(p_o), .count(c_o)
    );

    int nvec = 0;
    int nerr = 0;

    // left = enabled cycles still to be spent in DONE
    typedef struct packed {
        int cnt;
        int left;
        bit done;
        bit pulse;
    } m_t;

    m_t m_d = '0;
    m_t m_r = '0;
    m_t m_a = '0;
    m_t m_o = '0;

    function automatic m_t mstep(m_t m, int thr, bit rol, bit ar,
                                 int hc, bit c, bit e, bit xi);
        m_t n = m;
        n.pulse = 1'b0;
        if (c) begin
            n = '0;
        end else if (e) begin
            if (m.done) begin
                if (ar) begin
                    n.left = m.left - 1;
                    if (n.left == 0) begin
                        n.done = 1'b0;
                        n.cnt  = 0;
                    end
                end
            end else if (xi) begin
                n.cnt = m.cnt + 1;
                if (n.cnt >= thr) begin
                    n.cnt   = thr;
                    n.done  = 1'b1;
                    n.pulse = 1'b1;
                    n.left  = hc;
                end
            end else if (rol || m.cnt == 0) begin
                n.cnt = 0;
            end
        end
        return n;
    endfunction

    function automatic int mword(m_t m);
        int z1v;
        z1v = (!m.done && m.cnt >= 1) ? 1 : 0;
        return (z1v << 6) | (int'(m.done) << 5)
             | (int'(m.pulse) << 4) | m.cnt;
    endfunction

    function automatic int dword(logic a, logic b, logic p, int c);
        return (int'(a) << 6) | (int'(b) << 5) | (int'(p) << 4) | c;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_d <= '0;
            m_r <= '0;
            m_a <= '0;
            m_o <= '0;
        end else begin
            m_d <= mstep(m_d, 3, 1'b0, 1'b0, 4, clr, en, x);
            m_r <= mstep(m_r, 3, 1'b1, 1'b0, 4, clr, en, x);
            m_a <= mstep(m_a, 3, 1'b0, 1'b1, 4, clr, en, x);
            m_o <= mstep(m_o, 1, 1'b0, 1'b1, 1, clr, en, x);
        end
    end

    task automatic chk(string name, int act, int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    bit cmp_on = 1'b0;

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_def",
                dword(z1_d, z2_d, p_d, int'(c_d)), mword(m_d));
            chk("model_rol",
                dword(z1_r, z2_r, p_r, int'(c_r)), mword(m_r));
            chk("model_ar",
                dword(z1_a, z2_a, p_a, int'(c_a)), mword(m_a));
            chk("model_t1",
                dword(z1_o, z2_o, p_o, int'(c_o)), mword(m_o));
        end
    end

    task automatic cyc(bit c, bit e, bit xi);
        clr = c;
        en  = e;
        x   = xi;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t1c[5] = '{1, 2, 3, 3, 3};
        int t1a[5] = '{1, 1, 0, 0, 0};
        int t1b[5] = '{0, 0, 1, 1, 1};
        int t1p[5] = '{0, 0, 1, 0, 0};
        bit t2x[5] = '{1, 0, 0, 1, 1};
        int t2c[5] = '{1, 1, 1, 2, 3};
        bit t3x[6] = '{1, 1, 0, 1, 1, 1};
        int t3c[6] = '{1, 2, 0, 1, 2, 3};
        int t4c[10] = '{1, 2, 3, 3, 3, 3, 0, 1, 2, 3};
        int t4b[10] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 1};
        int t4p[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1};

        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        cmp_on = 1'b1;
        chk("rst_count", int'(c_d), 0);
        chk("rst_z", dword(z1_d, z2_d, p_d, 0), 0);

        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
            chk("t1_count", int'(c_d), t1c[i]);
            chk("t1_z1", int'(z1_d), t1a[i]);
            chk("t1_z2", int'(z2_d), t1b[i]);
            chk("t1_pulse", int'(p_d), t1p[i]);
            if (i == 0) begin
                chk("thr1_z2", int'(z2_o), 1);
                chk("thr1_z1", int'(z1_o), 0);
            end
        end
        cyc(1'b1, 1'b1, 1'b1);
        chk("clr_after_done", int'(c_d), 0);

        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, t2x[i]);
            chk("t2_count", int'(c_d), t2c[i]);
            chk("t2_z2", int'(z2_d), (i == 4) ? 1 : 0);
        end
        repeat (2) cyc(1'b0, 1'b1, 1'b0);
        chk("t2_sticky", int'(z2_d), 1);
        cyc(1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, t3x[i]);
            chk("t3_count", int'(c_r), t3c[i]);
            chk("t3_z2", int'(z2_r), (i == 5) ? 1 : 0);
        end
        cyc(1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
            chk("t4_count", int'(c_a), t4c[i]);
            chk("t4_z2", int'(z2_a), t4b[i]);
            chk("t4_pulse", int'(p_a), t4p[i]);
        end
        cyc(1'b1, 1'b1, 1'b0);

        repeat (2) cyc(1'b0, 1'b1, 1'b1);
        chk("t5_pre", int'(c_d), 2);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        chk("t5_hold", int'(c_d), 2);
        chk("t5_hold_z1", int'(z1_d), 1);
        cyc(1'b1, 1'b1, 1'b1);
        chk("t5_clr", dword(z1_d, z2_d, p_d, int'(c_d)), 0);

        repeat (2) cyc(1'b0, 1'b1, 1'b1);
        chk("t6_pre_run", int'(c_d), 2);
        reset_n = 1'b0;
        #2;
        chk("t6_async_run",
            dword(z1_d, z2_d, p_d, int'(c_d)), 0);
        reset_n = 1'b1;
        cyc(1'b0, 1'b1, 1'b1);
        chk("t6_first", int'(c_d), 1);
        repeat (2) cyc(1'b0, 1'b1, 1'b1);
        chk("t6_pre_done", int'(p_d), 1);
        reset_n = 1'b0;
        #2;
        chk("t6_async_done",
            dword(z1_d, z2_d, p_d, int'(c_d)), 0);
        reset_n = 1'b1;
        cyc(1'b0, 1'b1, 1'b1);
        chk("t6_rel", int'(c_d), 1);

        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
